multiplier_16x16: RTL and testbench
===================================

MULTIPLIER_16X16 -- requirements
Module: multiplier_16x16

Interface
REQ-001 Parameter: WIDTH, default 16, operand width in bits; the product is 2*WIDTH bits wide.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  operands a and b are valid this cycle.
REQ-005 a  input  WIDTH  multiplicand, unsigned.
REQ-006 b  input  WIDTH  multiplier, unsigned.
REQ-007 c  output  WIDTH  registered product, low WIDTH bits.
REQ-008 p  output  2*WIDTH  registered full-width product.
REQ-009 ovf  output  1  registered flag; 1 when product bits [2*WIDTH-1:WIDTH] are nonzero.
REQ-010 out_valid  output  1  c, p and ovf hold the result of a valid operand pair.

Function
REQ-011 The product SHALL be the unsigned value p = a*b, exact over 2*WIDTH bits, with no rounding or saturation.
REQ-012 c SHALL equal p[WIDTH-1:0], truncated modulo 2^WIDTH, with no saturation.
REQ-013 Latency SHALL be exactly 1 cycle: operands sampled at edge N with in_valid=1 appear on c/p/ovf after edge N, and out_valid=1 in the same cycle.
REQ-014 When in_valid=0 at an edge, c/p/ovf SHALL hold their previous values and out_valid SHALL go to 0 after that edge.
REQ-015 Back-to-back in_valid=1 cycles SHALL give one result per cycle with no bubbles and no backpressure; there is no ready input.
REQ-016 All outputs SHALL be driven directly from flops, with no combinational path from any input to any output.
REQ-017 Operands of 0 SHALL give p=0 and ovf=0; 1*x SHALL give p=x.
REQ-018 Any X on a or b while in_valid=0 SHALL NOT propagate to the outputs.

Reset
REQ-019 When rst_n=0 at a rising clk edge, c, p, ovf and out_valid SHALL all become 0 after that edge.
REQ-020 Reset SHALL take priority over in_valid, so an operand pair presented in a reset cycle is discarded.
REQ-021 The first rising edge with rst_n=1 and in_valid=1 SHALL capture normally; there are no warm-up cycles.

Structure
REQ-022 A shared package mult_pkg SHALL hold the WIDTH default (16) and the derived PWIDTH = 2*WIDTH constant.
REQ-023 The module SHALL have one sub-module, multiplier_core: a purely combinational unsigned WIDTH x WIDTH -> 2*WIDTH array of shifted-AND partial products summed in a tree.
REQ-024 The top level SHALL contain only the output registers, the ovf reduction and the valid/reset logic.
REQ-025 The module SHALL contain no latches, no initial blocks and no vendor multiplier primitives.

Verification
REQ-026 Basic multiply: a=3, b=4, in_valid=1 -> next cycle c=12, p=12, ovf=0, out_valid=1.
REQ-027 Width boundary: a=255, b=255 -> c=65025 (0xFE01), ovf=0; then a=256, b=256 -> c=0, p=0x0001_0000, ovf=1.
REQ-028 Maximum operands: a=0xFFFF, b=0xFFFF -> p=0xFFFE_0001, c=0x0001, ovf=1.
REQ-029 Hold: result 12 registered, then in_valid=0 with a=7, b=9 -> c stays 12, out_valid=0.
REQ-030 Reset mid-stream: continuous in_valid=1 stream with rst_n=0 for one edge -> c=0, p=0, ovf=0, out_valid=0; the next valid pair (5*6) gives c=30 one cycle later.
REQ-031 Random: 10,000 random pairs with random in_valid -> each output matches a reference model a*b delayed one cycle.

Source files
------------

// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
// Shared sizing constants for the multiplier block.
//   WIDTH  : default operand width in bits
//   PWIDTH : full product width (2*WIDTH)
// ---------------------------------------------------------------------------
package mult_pkg;
  localparam int WIDTH  = 16;
  localparam int PWIDTH = 2 * WIDTH;
endpackage

// File: rtl/multiplier_16x16_if.sv
// ---------------------------------------------------------------------------
// multiplier_16x16_if
// Operand/result bundle for the multiplier.
//   in_valid, a, b         : operand side (driven by master)
//   c, p, ovf, out_valid   : registered result side (driven by slave)
// Modports:
//   master : issues operands, observes results (testbench / upstream logic)
//   slave  : the multiplier itself
// ---------------------------------------------------------------------------
interface multiplier_16x16_if #(
  parameter int WIDTH = mult_pkg::WIDTH
);
  logic                 in_valid;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [WIDTH-1:0]     c;
  logic [2*WIDTH-1:0]   p;
  logic                 ovf;
  logic                 out_valid;

  modport master (
    output in_valid, a, b,
    input  c, p, ovf, out_valid
  );

  modport slave (
    input  in_valid, a, b,
    output c, p, ovf, out_valid
  );
endinterface

// File: rtl/multiplier_core.sv
// ---------------------------------------------------------------------------
// multiplier_core
// Purely combinational unsigned WIDTH x WIDTH -> 2*WIDTH multiplier.
// Each bit of b gates a shifted copy of a (one partial product per bit);
// the partial products are summed pairwise in a balanced binary tree.
//   a : multiplicand (unsigned)
//   b : multiplier (unsigned)
//   p : exact product
// ---------------------------------------------------------------------------
module multiplier_core #(
  parameter int WIDTH = mult_pkg::WIDTH
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p
);
  localparam int PWIDTH = 2 * WIDTH;
  // Tree depth and leaf count; the leaf row is padded with zeros up to a
  // power of two so every level halves cleanly.
  localparam int LEVELS = $clog2(WIDTH);
  localparam int NLEAF  = 1 << LEVELS;

  genvar gl, gi;
  generate
    for (gl = 0; gl <= LEVELS; gl++) begin : g_lvl
      localparam int N = NLEAF >> gl;
      logic [PWIDTH-1:0] w_sum [N];
      for (gi = 0; gi < N; gi++) begin : g_node
        if (gl == 0) begin : g_leaf
          if (gi < WIDTH) begin : g_pp
            assign w_sum[gi] = b[gi] ? (PWIDTH'(a) << gi) : '0;
          end else begin : g_pad
            assign w_sum[gi] = '0;
          end
        end else begin : g_add
          // The true product fits in PWIDTH bits, so no partial sum overflows.
          assign w_sum[gi] = g_lvl[gl-1].w_sum[2*gi] + g_lvl[gl-1].w_sum[2*gi+1];
        end
      end
    end
  endgenerate

  assign p = g_lvl[LEVELS].w_sum[0];
endmodule

// File: rtl/multiplier_16x16.sv
// ---------------------------------------------------------------------------
// multiplier_16x16
// Registered unsigned multiplier with one cycle of latency.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset, overrides in_valid
//   bus   : multiplier_16x16_if.slave
//             in_valid/a/b in; c (low half), p (full product),
//             ovf (upper half nonzero), out_valid out -- all from flops
// Results are only loaded on valid cycles, so c/p/ovf hold their last value
// (and ignore any garbage on a/b) while in_valid is low.
// ---------------------------------------------------------------------------
module multiplier_16x16 #(
  parameter int WIDTH = mult_pkg::WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  multiplier_16x16_if.slave  bus
);
  localparam int PWIDTH = 2 * WIDTH;

  logic [PWIDTH-1:0] w_prod;

  logic [WIDTH-1:0]  r_c;
  logic [PWIDTH-1:0] r_p;
  logic              r_ovf;
  logic              r_valid;

  multiplier_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a (bus.a),
    .b (bus.b),
    .p (w_prod)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_c     <= '0;
      r_p     <= '0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_c   <= w_prod[WIDTH-1:0];
        r_p   <= w_prod;
        r_ovf <= |w_prod[PWIDTH-1:WIDTH];
      end
    end
  end

  assign bus.c         = r_c;
  assign bus.p         = r_p;
  assign bus.ovf       = r_ovf;
  assign bus.out_valid = r_valid;
endmodule

// File: tb/tb_multiplier_16x16.sv
// ---------------------------------------------------------------------------
// tb_multiplier_16x16
// Stimulus pushes the expected product of every accepted operand pair into a
// queue; an independent monitor checks the DUT after every rising edge,
// popping on out_valid and otherwise checking the held / reset values.
// ---------------------------------------------------------------------------
module tb_multiplier_16x16;
  logic clk;
  logic rst_n;

  multiplier_16x16_if #(.WIDTH(16)) bus ();

  multiplier_16x16 #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int fails;
  logic [31:0] q_exp [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs (changed on the falling edge). Accepted pairs
  // get their reference product queued for the monitor.
  task automatic step(input logic rst_in, input logic v, input logic [15:0] xa, input logic [15:0] xb);
    longint unsigned prod;
    @(negedge clk);
    rst_n        = rst_in;
    bus.in_valid = v;
    bus.a        = v ? xa : 'x;
    bus.b        = v ? xb : 'x;
    if (rst_in && v) begin
      prod = longint'(xa) * longint'(xb);
      q_exp.push_back(prod[31:0]);
    end
  endtask

  // Directed spot-check with literal expectations, just after the edge that
  // follows the last step.
  task automatic expect_now(input string name, input logic [15:0] ec, input logic [31:0] ep,
                            input logic eo, input logic ev);
    @(posedge clk);
    #2;
    check({name, "_c"},     64'(bus.c),         64'(ec));
    check({name, "_p"},     64'(bus.p),         64'(ep));
    check({name, "_ovf"},   64'(bus.ovf),       64'(eo));
    check({name, "_valid"}, 64'(bus.out_valid), 64'(ev));
  endtask

  // Monitor / scoreboard
  initial begin
    logic        rs;
    logic [31:0] hold_p;
    logic [31:0] e;
    hold_p = '0;
    forever begin
      @(posedge clk);
      rs = rst_n;
      #1;
      if (!rs) begin
        hold_p = '0;
        check("mon_rst_valid", 64'(bus.out_valid), 64'd0);
        check("mon_rst_p",     64'(bus.p),         64'd0);
        check("mon_rst_c",     64'(bus.c),         64'd0);
        check("mon_rst_ovf",   64'(bus.ovf),       64'd0);
      end else if (bus.out_valid) begin
        if (q_exp.size() == 0) begin
          check("mon_spurious_valid", 64'(bus.out_valid), 64'd0);
        end else begin
          e      = q_exp.pop_front();
          hold_p = e;
          check("mon_p",   64'(bus.p),   64'(e));
          check("mon_c",   64'(bus.c),   64'(e % 32'h1_0000));
          check("mon_ovf", 64'(bus.ovf), 64'((e / 32'h1_0000) != 0));
        end
      end else begin
        check("mon_hold_p",   64'(bus.p),   64'(hold_p));
        check("mon_hold_c",   64'(bus.c),   64'(hold_p % 32'h1_0000));
        check("mon_hold_ovf", 64'(bus.ovf), 64'((hold_p / 32'h1_0000) != 0));
      end
    end
  end

  // Stimulus
  initial begin
    logic [15:0] ra, rb;
    logic        rv, rr;
    tests = 0;
    fails = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;

    step(0, 0, 0, 0);
    step(0, 1, 16'd77, 16'd88);           // pair in a reset cycle is discarded
    expect_now("reset", 16'd0, 32'd0, 1'b0, 1'b0);

    step(1, 1, 16'd3, 16'd4);
    expect_now("basic", 16'd12, 32'd12, 1'b0, 1'b1);
    step(1, 0, 16'd7, 16'd9);
    expect_now("hold", 16'd12, 32'd12, 1'b0, 1'b0);
    step(1, 1, 16'd255, 16'd255);
    expect_now("b255", 16'hFE01, 32'h0000_FE01, 1'b0, 1'b1);
    step(1, 1, 16'd256, 16'd256);
    expect_now("b256", 16'h0000, 32'h0001_0000, 1'b1, 1'b1);
    step(1, 1, 16'hFFFF, 16'hFFFF);
    expect_now("max", 16'h0001, 32'hFFFE_0001, 1'b1, 1'b1);
    step(1, 1, 16'd0, 16'h1234);
    expect_now("zero", 16'd0, 32'd0, 1'b0, 1'b1);
    step(1, 1, 16'd1, 16'hBEEF);
    expect_now("one", 16'hBEEF, 32'h0000_BEEF, 1'b0, 1'b1);

    step(1, 1, 16'd100, 16'd200);
    step(0, 1, 16'd9, 16'd9);
    expect_now("midrst", 16'd0, 32'd0, 1'b0, 1'b0);
    step(1, 1, 16'd5, 16'd6);
    expect_now("after_rst", 16'd30, 32'd30, 1'b0, 1'b1);

    for (int i = 0; i < 10000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom_range(0, 15))
        0:       ra = 16'hFFFF;
        1:       rb = 16'd0;
        2:       ra = 16'd1;
        default: ;
      endcase
      rv = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 199) != 0);
      step(rr, rv, ra, rb);
    end
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    @(posedge clk);
    #2;
    check("queue_drained", 64'(q_exp.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
